// File: rtl/nist_fail_monitor.sv
// Windowed fail monitor for the NIST test error lines: per-window fail flags,
// sticky/saturating statistics and a latched alarm. NIST_MON_LEVEL_EN selects level capture.
module nist_fail_monitor #(
  parameter  int N_TESTS      = 2,
  parameter  int WIN_LEN      = 128,
  parameter  int ALARM_THRESH = 3,
  parameter  int CNT_W        = 8,
  localparam int CONS_W       = $clog2(ALARM_THRESH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_TESTS-1:0] err_in,
  input  logic               clr,
  output logic               win_done,
  output logic [N_TESTS-1:0] win_fail,
  output logic [N_TESTS-1:0] sticky_fail,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic [CONS_W-1:0]  consec_cnt,
  output logic               alarm,
  output logic               busy
);

  localparam int CTR_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ALARM} state_t;

  state_t             state, state_nxt;
  logic [CTR_W-1:0]   win_ctr;
  logic [N_TESTS-1:0] pend, cap, fail_new;
  logic               win_end, any_fail, alarm_hit;
  logic [CONS_W-1:0]  consec_nxt;

`ifdef NIST_MON_LEVEL_EN
  assign cap = err_in;
`else
  logic [N_TESTS-1:0] err_prev;

  always_ff @(posedge clk) begin
    if (rst) err_prev <= '0;
    else     err_prev <= err_in;
  end

  assign cap = err_in & ~err_prev;
`endif

  assign win_end    = en && (win_ctr == CTR_W'(WIN_LEN - 1));
  // a capture on the closing cycle belongs to the window being closed
  assign fail_new   = pend | (cap & {N_TESTS{en}});
  assign any_fail   = |fail_new;
  assign consec_nxt = (consec_cnt == CONS_W'(ALARM_THRESH)) ? consec_cnt
                                                            : consec_cnt + CONS_W'(1);
  assign alarm_hit  = win_end && any_fail && !clr && (consec_nxt == CONS_W'(ALARM_THRESH));

  // window counter pauses while en is low instead of restarting
  always_ff @(posedge clk) begin
    if (rst)          win_ctr <= '0;
    else if (win_end) win_ctr <= '0;
    else if (en)      win_ctr <= win_ctr + CTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      win_done <= 1'b0;
      win_fail <= '0;
    end else begin
      win_done <= win_end;
      if (win_end) begin
        pend     <= '0;
        win_fail <= fail_new;
      end else if (en) begin
        pend     <= pend | cap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sticky_fail <= '0;
      fail_cnt    <= '0;
      consec_cnt  <= '0;
    end else if (win_end) begin
      if (any_fail) begin
        sticky_fail <= sticky_fail | fail_new;
        fail_cnt    <= (fail_cnt == '1) ? fail_cnt : fail_cnt + CNT_W'(1);
        consec_cnt  <= consec_nxt;
      end else begin
        consec_cnt  <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (alarm_hit) state_nxt = S_ALARM;
               else if (en)   state_nxt = S_RUN;
      S_RUN:   if (alarm_hit) state_nxt = S_ALARM;
               else if (!en)  state_nxt = S_IDLE;
      S_ALARM: if (clr)       state_nxt = en ? S_RUN : S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    alarm = (state == S_ALARM);
    busy  = (state != S_IDLE);
  end

endmodule

// File: tb/tb_nist_fail_monitor.sv
// Directed bench for nist_fail_monitor with default parameters; expectations
// are hand-computed per window (define NIST_MON_LEVEL_EN to check level capture).
module tb_nist_fail_monitor;

  logic       clk = 1'b0;
  logic       rst, en, clr;
  logic [1:0] err_in;
  logic       win_done, alarm, busy;
  logic [1:0] win_fail, sticky_fail, consec_cnt;
  logic [7:0] fail_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int pulses;

  nist_fail_monitor #(.N_TESTS(2), .WIN_LEN(128), .ALARM_THRESH(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .err_in(err_in), .clr(clr),
    .win_done(win_done), .win_fail(win_fail), .sticky_fail(sticky_fail),
    .fail_cnt(fail_cnt), .consec_cnt(consec_cnt), .alarm(alarm), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_cnt(input int n, output int p);
    p = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (win_done) p++;
    end
  endtask

  task automatic chk_stats(input string tag, input logic [1:0] wf, input logic [1:0] st,
                           input logic [7:0] fc, input logic [1:0] cc, input logic al);
    chk({tag, ".win_fail"}, 32'(win_fail), 32'(wf));
    chk({tag, ".sticky"},   32'(sticky_fail), 32'(st));
    chk({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(fc));
    chk({tag, ".consec"},   32'(consec_cnt), 32'(cc));
    chk({tag, ".alarm"},    32'(alarm), 32'(al));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; err_in = 2'b00;
    step(2);
    rst = 1'b0;
    chk("rst.win_done", 32'(win_done), 0);
    chk("rst.busy", 32'(busy), 0);
    chk_stats("rst", 2'b00, 2'b00, 8'd0, 2'd0, 1'b0);

    // windows 1-2: clean
    en = 1'b1;
    step(127);
    chk("w1.pre_done", 32'(win_done), 0);
    step(1);
    chk("w1.done", 32'(win_done), 1);
    chk("w1.busy", 32'(busy), 1);
    step(1);
    chk("w1.done_drop", 32'(win_done), 0);
    step(127);
    chk("w2.done", 32'(win_done), 1);
    chk_stats("w2", 2'b00, 2'b00, 8'd0, 2'd0, 1'b0);

    // window 3: single pulse on test 0 at cycle 40; window 4 clean
    step(39);
    err_in = 2'b01; step(1);
    err_in = 2'b00; step(88);
    chk("w3.done", 32'(win_done), 1);
    chk_stats("w3", 2'b01, 2'b01, 8'd1, 2'd1, 1'b0);
    step(128);
    chk_stats("w4", 2'b00, 2'b01, 8'd1, 2'd0, 1'b0);

    // windows 5-7: test 1 rises once per window -> alarm at third
    for (int w = 0; w < 3; w++) begin
      step(10);
      err_in = 2'b10; step(1);
      err_in = 2'b00; step(117);
      case (w)
        0: chk_stats("w5", 2'b10, 2'b11, 8'd2, 2'd1, 1'b0);
        1: chk_stats("w6", 2'b10, 2'b11, 8'd3, 2'd2, 1'b0);
        default: chk_stats("w7", 2'b10, 2'b11, 8'd4, 2'd3, 1'b1);
      endcase
    end
    step(128);
    chk_stats("w8", 2'b00, 2'b11, 8'd4, 2'd0, 1'b1);
    chk("w8.busy", 32'(busy), 1);
    clr = 1'b1; step(1);
    clr = 1'b0;
    chk_stats("clr", 2'b00, 2'b00, 8'd0, 2'd0, 1'b0);
    chk("clr.busy", 32'(busy), 1);

    // window 9: edge at cycle 50, pause 50 cycles at position 100
    step(48);
    err_in = 2'b10; step(1);
    err_in = 2'b00; step(50);
    en = 1'b0;
    run_cnt(50, pulses);
    chk("pause.pulses", 32'(pulses), 0);
    chk("pause.busy", 32'(busy), 0);
    en = 1'b1;
    run_cnt(27, pulses);
    chk("resume.pulses", 32'(pulses), 0);
    step(1);
    chk("w9.done", 32'(win_done), 1);
    chk_stats("w9", 2'b10, 2'b10, 8'd1, 2'd1, 1'b0);

    // window 10: rise on last cycle coinciding with clr
    step(127);
    err_in = 2'b01; clr = 1'b1; step(1);
    clr = 1'b0; err_in = 2'b00;
    chk("w10.done", 32'(win_done), 1);
    chk_stats("w10", 2'b01, 2'b00, 8'd0, 2'd0, 1'b0);

    // windows 11-13: test 0 held high
    step(1);
    err_in = 2'b01; step(127);
    chk_stats("w11", 2'b01, 2'b01, 8'd1, 2'd1, 1'b0);
    step(128);
`ifdef NIST_MON_LEVEL_EN
    chk_stats("w12", 2'b01, 2'b01, 8'd2, 2'd2, 1'b0);
    step(128);
    chk_stats("w13", 2'b01, 2'b01, 8'd3, 2'd3, 1'b1);
    en = 1'b0; err_in = 2'b00; step(1);
    chk("alarm_hold.busy", 32'(busy), 1);
    chk("alarm_hold.alarm", 32'(alarm), 1);
`else
    chk_stats("w12", 2'b00, 2'b01, 8'd1, 2'd0, 1'b0);
    step(128);
    chk_stats("w13", 2'b00, 2'b01, 8'd1, 2'd0, 1'b0);
    en = 1'b0; err_in = 2'b00; step(1);
    chk("idle.busy", 32'(busy), 0);
    chk("idle.alarm", 32'(alarm), 0);
`endif

    // reset overrides everything
    rst = 1'b1; en = 1'b1; clr = 1'b0; err_in = 2'b11; step(1);
    chk("rst2.win_done", 32'(win_done), 0);
    chk("rst2.busy", 32'(busy), 0);
    chk_stats("rst2", 2'b00, 2'b00, 8'd0, 2'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
